// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with start/stall/halt and absolute/relative branches
// Optional return-address stack (call/ret/stack_err) enabled by defining CALL_STACK_EN.
module pc_sequencer #(
  parameter int D           = 10,
  parameter int START_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_req,
  input  logic         jump_abs,
  input  logic         jump_rel,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         wrapped
`ifdef CALL_STACK_EN
  ,
  input  logic         call,
  input  logic         ret,
  output logic         stack_err
`endif
);

  // The return stack shifts entries rather than indexing, so it needs at least two slots.
  if (STACK_DEPTH < 2) begin : g_bad_depth
    $error("pc_sequencer: STACK_DEPTH must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         wrapped_q, wrapped_d;
  logic [D-1:0] pc_inc;
  logic         pc_at_max;

`ifdef CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [STACK_DEPTH-1:0][D-1:0] stack_q, stack_d;
  logic [SPW-1:0]                sp_q, sp_d;
  logic                          err_q, err_d;
`endif

  assign pc_inc    = pc_q + D'(1);
  assign pc_at_max = &pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrapped_d = wrapped_q;
`ifdef CALL_STACK_EN
    stack_d   = stack_q;
    sp_d      = sp_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d   = S_RUN;
          pc_d      = D'(START_ADDR);
          wrapped_d = 1'b0;
`ifdef CALL_STACK_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jump_abs) begin
          pc_d = target;
        end else if (jump_rel) begin
          pc_d = pc_q + target;
`ifdef CALL_STACK_EN
        end else if (call && sp_q != SP_FULL) begin
          // Newest entry lives in slot 0; older entries shift toward the top.
          stack_d = {stack_q[STACK_DEPTH-2:0], pc_inc};
          sp_d    = sp_q + SPW'(1);
          pc_d    = target;
        end else if (!call && ret && sp_q != '0) begin
          pc_d    = stack_q[0];
          stack_d = {{D{1'b0}}, stack_q[STACK_DEPTH-1:1]};
          sp_d    = sp_q - SPW'(1);
`endif
        end else begin
`ifdef CALL_STACK_EN
          // Reaching here with call/ret set means a full push or empty pop.
          if (call || ret) begin
            err_d = 1'b1;
          end
`endif
          pc_d = pc_inc;
          if (pc_at_max) begin
            wrapped_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          pc_d      = D'(START_ADDR);
          wrapped_d = 1'b0;
`ifdef CALL_STACK_EN
          err_d     = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      wrapped_q <= 1'b0;
`ifdef CALL_STACK_EN
      stack_q   <= '0;
      sp_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
`ifdef CALL_STACK_EN
      stack_q   <= stack_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
`endif
    end
  end

  assign prog_ctr = pc_q;
  assign running  = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign wrapped  = wrapped_q;
`ifdef CALL_STACK_EN
  assign stack_err = err_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a reference model
// Call-stack scenarios are included when CALL_STACK_EN is defined.
module tb_pc_sequencer;
  localparam int D           = 10;
  localparam int START_ADDR  = 0;
  localparam int STACK_DEPTH = 4;
  localparam int MOD         = 1 << D;

  logic         clk = 1'b0;
  logic         reset, start, stall, halt_req, jump_abs, jump_rel;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         running, done, wrapped;
  logic         err_obs;
`ifdef CALL_STACK_EN
  logic         call, ret, stack_err;
  assign err_obs = stack_err;
`else
  assign err_obs = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 = idle, 1 = run, 2 = done
  int m_mode;
  int m_pc;
  bit m_wrap;
  bit m_err;
  int m_stack[$];

  pc_sequencer #(.D(D), .START_ADDR(START_ADDR), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall),
    .halt_req (halt_req),
    .jump_abs (jump_abs),
    .jump_rel (jump_rel),
    .target   (target),
    .prog_ctr (prog_ctr),
    .running  (running),
    .done     (done),
    .wrapped  (wrapped)
`ifdef CALL_STACK_EN
    ,
    .call     (call),
    .ret      (ret),
    .stack_err(stack_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic int sext(input int t);
    return (t >= MOD / 2) ? t - MOD : t;
  endfunction

  function automatic void model_increment();
    if (m_pc == MOD - 1) begin
      m_pc   = 0;
      m_wrap = 1'b1;
    end else begin
      m_pc = m_pc + 1;
    end
  endfunction

  function automatic void model_step();
    bit c, r;
`ifdef CALL_STACK_EN
    c = call;
    r = ret;
`else
    c = 1'b0;
    r = 1'b0;
`endif
    if (reset) begin
      m_mode = 0; m_pc = 0; m_wrap = 0; m_err = 0;
      m_stack.delete();
    end else if (m_mode == 0 || m_mode == 2) begin
      if (start) begin
        m_mode = 1; m_pc = START_ADDR; m_wrap = 0; m_err = 0;
      end else if (m_mode == 0) begin
        m_pc = 0;
      end
    end else begin
      if (halt_req)      m_mode = 2;
      else if (stall)    m_pc = m_pc;
      else if (jump_abs) m_pc = int'(target);
      else if (jump_rel) m_pc = ((m_pc + sext(int'(target))) % MOD + MOD) % MOD;
      else if (c) begin
        if (m_stack.size() == STACK_DEPTH) begin
          m_err = 1'b1;
          model_increment();
        end else begin
          m_stack.push_back((m_pc + 1) % MOD);
          m_pc = int'(target);
        end
      end else if (r) begin
        if (m_stack.size() == 0) begin
          m_err = 1'b1;
          model_increment();
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else begin
        model_increment();
      end
    end
  endfunction

  function automatic logic [D+3:0] dut_vec();
    return {prog_ctr, running, done, wrapped, err_obs};
  endfunction

  function automatic logic [D+3:0] model_vec();
    return {D'(m_pc), m_mode == 1, m_mode == 2, m_wrap, m_err};
  endfunction

  task automatic clear_inputs();
    start = 0; stall = 0; halt_req = 0; jump_abs = 0; jump_rel = 0; target = '0;
`ifdef CALL_STACK_EN
    call = 0; ret = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    n_checks++;
    if ({prog_ctr, running, done, wrapped, err_obs} !== {{D{1'b0}}, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%0d run=%0b done=%0b wrap=%0b err=%0b required all zero",
               prog_ctr, running, done, wrapped, err_obs);
    end
    reset = 0;
    tick();
    n_checks++;
    if (prog_ctr !== '0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got pc=%0d run=%0b required pc=0 run=0", prog_ctr, running);
    end
  endtask

  task automatic test_sequential();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (prog_ctr !== D'(START_ADDR + i) || running !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_count[%0d]: got pc=%0d run=%0b done=%0b required pc=%0d run=1 done=0",
                 i, prog_ctr, running, done, START_ADDR + i);
      end
    end
  endtask

  task automatic test_jump_rel();
    int k;
    k = 0;
    while (prog_ctr !== D'(20) && k < 100) begin
      tick();
      k++;
    end
    n_checks++;
    if (prog_ctr !== D'(20)) begin
      n_fail++;
      $display("FAIL reach_20: got pc=%0d required 20", prog_ctr);
    end
    jump_rel = 1; target = 10'h3FB;
    tick();
    clear_inputs();
    n_checks++;
    if (prog_ctr !== D'(15)) begin
      n_fail++;
      $display("FAIL jump_rel_neg: got pc=%0d required 15", prog_ctr);
    end
  endtask

  task automatic test_priority_stall();
    jump_abs = 1; target = 3;
    tick();
    jump_rel = 1; target = 111;
    tick();
    clear_inputs();
    n_checks++;
    if (prog_ctr !== D'(111)) begin
      n_fail++;
      $display("FAIL abs_beats_rel: got pc=%0d required 111", prog_ctr);
    end
    jump_abs = 1; target = 5;
    tick();
    stall = 1; target = 200;
    tick();
    n_checks++;
    if (prog_ctr !== D'(5)) begin
      n_fail++;
      $display("FAIL stall_drops_jump: got pc=%0d required 5", prog_ctr);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (prog_ctr !== D'(6)) begin
      n_fail++;
      $display("FAIL stall_release: got pc=%0d required 6", prog_ctr);
    end
  endtask

  task automatic test_wrap_halt();
    jump_abs = 1; target = 1023;
    tick();
    clear_inputs();
    n_checks++;
    if (prog_ctr !== D'(1023) || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL at_max: got pc=%0d wrap=%0b required pc=1023 wrap=0", prog_ctr, wrapped);
    end
    tick();
    n_checks++;
    if (prog_ctr !== '0 || wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL inc_wrap: got pc=%0d wrap=%0b required pc=0 wrap=1", prog_ctr, wrapped);
    end
    halt_req = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); jump_abs = 1'($urandom); jump_rel = 1'($urandom);
      halt_req = 1'($urandom); target = D'($urandom);
      tick();
      n_checks++;
      if (prog_ctr !== '0 || done !== 1'b1 || running !== 1'b0 || wrapped !== 1'b1) begin
        n_fail++;
        $display("FAIL done_frozen[%0d]: got pc=%0d done=%0b run=%0b wrap=%0b required pc=0 done=1 run=0 wrap=1",
                 i, prog_ctr, done, running, wrapped);
      end
    end
    clear_inputs();
    start = 1;
    tick();
    start = 0;
    n_checks++;
    if (prog_ctr !== D'(START_ADDR) || running !== 1'b1 || done !== 1'b0 || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_from_done: got pc=%0d run=%0b done=%0b wrap=%0b required pc=%0d run=1 done=0 wrap=0",
               prog_ctr, running, done, wrapped, START_ADDR);
    end
  endtask

  task automatic test_reset_mid_run();
    jump_abs = 1; target = 84;
    tick();
    n_checks++;
    if (prog_ctr !== D'(84)) begin
      n_fail++;
      $display("FAIL reach_84: got pc=%0d required 84", prog_ctr);
    end
    reset = 1; start = 1; halt_req = 1;
    tick();
    reset = 0;
    clear_inputs();
    n_checks++;
    if (prog_ctr !== '0 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got pc=%0d run=%0b done=%0b required pc=0 run=0 done=0",
               prog_ctr, running, done);
    end
    jump_abs = 1; target = 77;
    tick();
    clear_inputs();
    n_checks++;
    if (prog_ctr !== '0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_jump: got pc=%0d run=%0b required pc=0 run=0", prog_ctr, running);
    end
    start = 1;
    tick();
    start = 0;
  endtask

`ifdef CALL_STACK_EN
  task automatic test_call_stack();
    reset = 1;
    tick();
    reset = 0; start = 1;
    tick();
    clear_inputs();
    jump_abs = 1; target = 10;
    tick();
    clear_inputs();
    call = 1; target = 99;
    tick();
    clear_inputs();
    n_checks++;
    if (prog_ctr !== D'(99)) begin
      n_fail++;
      $display("FAIL call_target: got pc=%0d required 99", prog_ctr);
    end
    ret = 1;
    tick();
    clear_inputs();
    n_checks++;
    if (prog_ctr !== D'(11) || stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_addr: got pc=%0d err=%0b required pc=11 err=0", prog_ctr, stack_err);
    end
    for (int i = 0; i < 5; i++) begin
      call = 1; target = D'(200 + i);
      tick();
      n_checks++;
      if (i < 4) begin
        if (prog_ctr !== D'(200 + i) || stack_err !== 1'b0) begin
          n_fail++;
          $display("FAIL nested_call[%0d]: got pc=%0d err=%0b required pc=%0d err=0",
                   i, prog_ctr, stack_err, 200 + i);
        end
      end else if (prog_ctr !== D'(204) || stack_err !== 1'b1) begin
        n_fail++;
        $display("FAIL call_overflow: got pc=%0d err=%0b required pc=204 err=1", prog_ctr, stack_err);
      end
    end
    clear_inputs();
    reset = 1;
    tick();
    reset = 0; start = 1;
    tick();
    clear_inputs();
    ret = 1;
    tick();
    clear_inputs();
    n_checks++;
    if (prog_ctr !== D'(START_ADDR + 1) || stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_underflow: got pc=%0d err=%0b required pc=%0d err=1",
               prog_ctr, stack_err, START_ADDR + 1);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(99) == 0);
      start    = ($urandom_range(15) == 0);
      stall    = ($urandom_range(5) == 0);
      halt_req = ($urandom_range(49) == 0);
      jump_abs = ($urandom_range(7) == 0);
      jump_rel = ($urandom_range(7) == 0);
      target   = ($urandom_range(3) == 0) ? D'(MOD - 1 - $urandom_range(3)) : D'($urandom);
`ifdef CALL_STACK_EN
      call     = ($urandom_range(5) == 0);
      ret      = ($urandom_range(5) == 0);
`endif
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got {pc,run,done,wrap,err}=%h required %h", i, dut_vec(), model_vec());
      end
    end
    clear_inputs();
    reset = 0;
  endtask

  initial begin
    m_mode = 0; m_pc = 0; m_wrap = 0; m_err = 0;
    reset = 1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_jump_rel();
    test_priority_stall();
    test_wrap_halt();
    test_reset_mid_run();
`ifdef CALL_STACK_EN
    test_call_stack();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
